mealy_non_overlapping_detector: RTL and testbench



---
 rtl/mealy_non_overlapping_detector.sv | 78 +++++++
 tb/tb_mealy_non_overlapping_detector.sv | 116 +++++++++++
 2 files changed

// File: rtl/mealy_non_overlapping_detector.sv
// ---------------------------------------------------------------------------
// mealy_non_overlapping_detector
// Serial Mealy pattern detector, non-overlapping, KMP fallback on mismatch.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mealy_non_overlapping_detector #(
  parameter int PAT_WIDTH = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int SW = (PAT_WIDTH > 2) ? $clog2(PAT_WIDTH) : 1;
  localparam logic [SW-1:0] LAST = SW'(PAT_WIDTH - 1);

  // Next state for "s matched bits followed by b": longest proper prefix of
  // PATTERN that is a suffix of that string; a full match restarts at S0.
  function automatic int calc_next(input int s, input logic b);
    int best;
    int idx;
    logic ok;
    logic cb;
    logic pb;
    logic [PAT_WIDTH-1:0] t;
    best = 0;
    if (s == PAT_WIDTH - 1 && b == PATTERN[0]) return 0;
    for (int k = 1; k < PAT_WIDTH; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int j = 0; j < PAT_WIDTH; j++) begin
          if (j < k) begin
            idx = s + 1 - k + j;
            if (idx < s) begin
              t  = PATTERN >> (PAT_WIDTH - 1 - idx);
              cb = t[0];
            end else begin
              cb = b;
            end
            t  = PATTERN >> (PAT_WIDTH - 1 - j);
            pb = t[0];
            if (pb != cb) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  logic [SW-1:0] next_on0 [PAT_WIDTH];
  logic [SW-1:0] next_on1 [PAT_WIDTH];

  for (genvar s = 0; s < PAT_WIDTH; s++) begin : g_state
    localparam int N0 = calc_next(s, 1'b0);
    localparam int N1 = calc_next(s, 1'b1);
    assign next_on0[s] = SW'(N0);
    assign next_on1[s] = SW'(N1);
  end

  logic [SW-1:0] state;
  logic [SW-1:0] state_next;

  assign state_next = in ? next_on1[state] : next_on0[state];
  assign out        = (state == LAST) && (in == PATTERN[0]) && rst;

  always_ff @(posedge clk) begin
    if (!rst) state <= '0;
    else      state <= state_next;
  end

endmodule

`default_nettype wire

// File: tb/tb_mealy_non_overlapping_detector.sv
// ---------------------------------------------------------------------------
// tb_mealy_non_overlapping_detector
// Directed and random checks of the default 1011 detector.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mealy_non_overlapping_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in  = 1'b0;
  logic out;

  int checks = 0;
  int errors = 0;

  mealy_non_overlapping_detector #(
    .PAT_WIDTH(4),
    .PATTERN  (4'b1011)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in (in),
    .out(out)
  );

  always #5 clk = ~clk;

  task automatic check(input logic exp, input string tag);
    checks++;
    assert (out === exp) else begin
      errors++;
      $error("FAIL %s: out=%b expected=%b", tag, out, exp);
    end
  endtask

  // Hold reset across one posedge with the given input bit.
  task automatic do_reset(input logic b, input string tag);
    @(negedge clk);
    rst = 1'b0;
    in  = b;
    #1;
    check(1'b0, tag);
    @(posedge clk);
  endtask

  task automatic step(input logic b, input logic exp, input string tag);
    @(negedge clk);
    rst = 1'b1;
    in  = b;
    #1;
    check(exp, tag);
  endtask

  // Bits and expectations are left-aligned: bit 15 is applied first.
  task automatic run_seq(input logic [15:0] bits, input logic [15:0] exps,
                         input int n, input string tag);
    logic [15:0] b;
    logic [15:0] e;
    b = bits;
    e = exps;
    for (int i = 0; i < n; i++) begin
      step(b[15], e[15], $sformatf("%s[%0d]", tag, i + 1));
      b = b << 1;
      e = e << 1;
    end
  endtask

  initial begin
    logic [3:0] win;
    int cnt;
    logic b;
    logic exp;

    // Reset period: out low regardless of in.
    do_reset(1'b1, "reset_in1");
    do_reset(1'b0, "reset_in0");
    do_reset(1'b1, "reset_in1b");

    run_seq(16'b1011011_000000000, 16'b0001000_000000000, 7, "nonoverlap");
    do_reset(1'b0, "rst_a");
    run_seq(16'b10111011_00000000, 16'b00010001_00000000, 8, "back2back");
    do_reset(1'b0, "rst_b");
    run_seq(16'b101011_0000000000, 16'b000001_0000000000, 6, "s3_fallback");
    do_reset(1'b0, "rst_c");
    run_seq(16'b11011_00000000000, 16'b00001_00000000000, 5, "s1_selfloop");

    // Reset while in S3 with the completing bit present: out must stay low.
    do_reset(1'b0, "rst_d");
    run_seq(16'b101_0000000000000, 16'b000_0000000000000, 3, "midmatch");
    do_reset(1'b1, "midmatch_rst");
    step(1'b1, 1'b0, "after_rst_1");
    // From S1, 0,1,1 completes a match; from any stale state it would not.
    run_seq(16'b011_0000000000000, 16'b001_0000000000000, 3, "post_rst");

    // Random stream against a window model of bits since the last match.
    for (int i = 0; i < 3; i++) do_reset(1'($urandom), "rand_reset");
    win = '0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      b   = 1'($urandom);
      win = {win[2:0], b};
      cnt++;
      exp = (cnt >= 4) && (win == 4'b1011);
      step(b, exp, $sformatf("random[%0d]", i));
      if (exp) cnt = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
